frame_aligner: RTL and testbench

FRAME_ALIGNER -- requirements
Module: frame_aligner

---
 rtl/frame_aligner.sv | 118 +++++++++++
 tb/tb_frame_aligner.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/frame_aligner.sv
// frame_aligner: finds a 40-bit frame boundary in a variable-rate bit stream via header search
// and bitslip, then emits aligned frames while locked and counts header and sampler errors.
module frame_aligner #(
   parameter logic [15:0] HDR_PATTERN = 16'h3C5C,
   parameter int          LOCK_CNT    = 4,
   parameter int          UNLOCK_CNT  = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  rate,
   input  logic [31:0] din,
   input  logic        din_err,
   input  logic        clr_cnt,
   output logic [39:0] frame,
   output logic        frame_valid,
   output logic        locked,
   output logic [15:0] hdr_err_cnt,
   output logic [15:0] din_err_cnt
);
   localparam logic [7:0] LOCK_N   = 8'(LOCK_CNT);
   localparam logic [7:0] UNLOCK_N = 8'(UNLOCK_CNT);
   typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;
   state_t      state, state_nx;
   logic [71:0] acc, acc_nx, comb_buf, shifted;
   logic [6:0]  fill, fill_nx, n, avail, cons;
   logic        slip, slip_nx;
   logic [1:0]  prev_rate;
   logic [7:0]  good_cnt, good_nx, miss_cnt, miss_nx;
   logic [31:0] din_m;
   logic [39:0] cand;
   logic        cand_ok, match, rate_chg, bitslip, emit, hdr_inc;
   // acc holds bits oldest-first from bit 0; slip is a one-bit discard owed from the last cycle
   always_comb begin
      n        = rate == 2'b00 ? 7'd8 : rate == 2'b01 ? 7'd16 : 7'd32;
      din_m    = rate == 2'b00 ? {24'b0, din[7:0]} : rate == 2'b01 ? {16'b0, din[15:0]} : din;
      comb_buf = acc | ({40'b0, din_m} << fill);
      shifted  = comb_buf >> slip;
      avail    = fill + n - {6'b0, slip};
      cand_ok  = avail >= 7'd40;
      cand     = {<<{shifted[39:0]}};
      match    = cand[39:24] == HDR_PATTERN;
      rate_chg = rate != prev_rate;
      bitslip  = cand_ok && !match && state != LOCKED;
      cons     = !cand_ok ? 7'd0 : bitslip ? 7'd41 : 7'd40;
      fill_nx  = (rate_chg || cons > avail) ? 7'd0 : avail - cons;
      slip_nx  = !rate_chg && cons > avail;
      acc_nx   = rate_chg ? 72'b0 : shifted >> cons;
   end
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state    <= SEARCH;
         good_cnt <= '0;
         miss_cnt <= '0;
      end else begin
         state    <= state_nx;
         good_cnt <= good_nx;
         miss_cnt <= miss_nx;
      end
   always_comb begin
      state_nx = state;
      good_nx  = good_cnt;
      miss_nx  = miss_cnt;
      if (rate_chg) begin
         state_nx = SEARCH;
         good_nx  = '0;
         miss_nx  = '0;
      end else if (cand_ok) begin
         case (state)
            SEARCH: if (match) begin
               state_nx = VERIFY;
               good_nx  = 8'd1;
            end
            VERIFY: if (match) begin
               good_nx  = good_cnt + 8'd1;
               state_nx = good_nx == LOCK_N ? LOCKED : VERIFY;
            end else begin
               state_nx = SEARCH;
               good_nx  = '0;
            end
            LOCKED: if (match) miss_nx = '0;
            else begin
               miss_nx = miss_cnt + 8'd1;
               if (miss_nx == UNLOCK_N) begin
                  state_nx = SEARCH;
                  miss_nx  = '0;
                  good_nx  = '0;
               end
            end
            default: state_nx = SEARCH;
         endcase
      end
   end
   always_comb begin
      locked  = state == LOCKED;
      emit    = cand_ok && !rate_chg && state == LOCKED;
      hdr_inc = emit && !match;
   end
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         acc         <= '0;
         fill        <= '0;
         slip        <= 1'b0;
         prev_rate   <= 2'b10;
         frame       <= '0;
         frame_valid <= 1'b0;
         hdr_err_cnt <= '0;
         din_err_cnt <= '0;
      end else begin
         acc         <= acc_nx;
         fill        <= fill_nx;
         slip        <= slip_nx;
         prev_rate   <= rate;
         frame       <= emit ? cand : frame;
         frame_valid <= emit;
         hdr_err_cnt <= clr_cnt ? 16'd0 : (hdr_inc && hdr_err_cnt != 16'hFFFF) ? hdr_err_cnt + 16'd1 : hdr_err_cnt;
         din_err_cnt <= clr_cnt ? 16'd0 : (din_err && din_err_cnt != 16'hFFFF) ? din_err_cnt + 16'd1 : din_err_cnt;
      end
endmodule

// File: tb/tb_frame_aligner.sv
// tb_frame_aligner: directed bench for frame_aligner; streams hand-built frames MSB-first
// and compares locking, emitted frames, gaps and counters against hand-computed expectations.
module tb_frame_aligner;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [1:0]  rate = 2'b10;
   logic [31:0] din = '0;
   logic        din_err = 1'b0;
   logic        clr_cnt = 1'b0;
   logic [39:0] frame;
   logic        frame_valid, locked;
   logic [15:0] hdr_err_cnt, din_err_cnt;
   int          total = 0, bad = 0;
   bit          bq[$];
   logic [39:0] expf[$];
   logic [39:0] last_frame;
   int          ei, nf, cyc_n, last_cyc, gap, last_idx;

   frame_aligner dut (
      .clk(clk), .reset(reset), .rate(rate), .din(din), .din_err(din_err), .clr_cnt(clr_cnt),
      .frame(frame), .frame_valid(frame_valid), .locked(locked),
      .hdr_err_cnt(hdr_err_cnt), .din_err_cnt(din_err_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // low byte left zero so no shifted header can look like a real one during search
   function automatic logic [39:0] mk(input logic [15:0] h, input int i);
      return {h, 16'(i * 4919 + 1234), 8'h00};
   endfunction

   task automatic push_frame(input logic [39:0] f);
      for (int b = 39; b >= 0; b--) bq.push_back(f[b]);
      expf.push_back(f);
   endtask

   task automatic cyc();
      int nb;
      nb = rate == 2'b00 ? 8 : rate == 2'b01 ? 16 : 32;
      din = '0;
      for (int b = 0; b < nb; b++) if (bq.size() > 0) din[b] = bq.pop_front();
      @(posedge clk);
      #1;
      cyc_n++;
      if (frame_valid) begin
         if (ei < expf.size()) chk("frame", frame, expf[ei]);
         else chk("extra_frame", {39'b0, frame_valid}, 40'd0);
         gap = cyc_n - last_cyc;
         last_cyc = cyc_n;
         last_frame = frame;
         last_idx = ei;
         ei++;
         nf++;
      end else if (nf > 0) chk("hold", frame, last_frame);
   endtask

   task automatic reset_dut(input logic [1:0] r);
      reset = 1'b0;
      rate = r;
      @(posedge clk);
      #1;
      reset = 1'b1;
      bq.delete();
      expf.delete();
      ei = 0; nf = 0; cyc_n = 0; last_cyc = 0; last_idx = -1;
      if (r != 2'b10) cyc();
   endtask

   initial begin
      #1;
      chk("rst_frame", frame, 40'h0);
      chk("rst_valid", {39'b0, frame_valid}, 40'd0);
      chk("rst_locked", {39'b0, locked}, 40'd0);
      chk("rst_hdr", {24'b0, hdr_err_cnt}, 40'd0);
      chk("rst_dinerr", {24'b0, din_err_cnt}, 40'd0);
      // aligned stream at 32 bits/cycle
      reset_dut(2'b10);
      for (int i = 0; i < 12; i++) push_frame(mk(16'h3C5C, i));
      ei = 4;
      repeat (4) cyc();
      chk("lock_early", {39'b0, locked}, 40'd0);
      cyc();
      chk("lock_5", {39'b0, locked}, 40'd1);
      chk("no_emit_4th", {39'b0, frame_valid}, 40'd0);
      while (bq.size() > 0) cyc();
      chk("n_aligned", 40'(nf), 40'd8);
      // seven junk bits in front
      reset_dut(2'b10);
      for (int i = 0; i < 7; i++) bq.push_back(1'b0);
      for (int i = 0; i < 16; i++) push_frame(mk(16'h3C5C, i + 20));
      ei = 11;
      while (bq.size() > 0) cyc();
      chk("n_junk", 40'(nf), 40'd5);
      chk("lock_junk", {39'b0, locked}, 40'd1);
      // corrupted headers while locked
      reset_dut(2'b10);
      for (int i = 0; i < 12; i++)
         push_frame(mk((i == 6 || i == 7 || i >= 9) ? 16'h3C5D : 16'h3C5C, i + 40));
      ei = 4;
      while (bq.size() > 0) begin
         cyc();
         if (frame_valid && last_idx == 8) begin
            chk("lock_after_2bad", {39'b0, locked}, 40'd1);
            chk("hdr_2", {24'b0, hdr_err_cnt}, 40'd2);
         end
         if (frame_valid && last_idx == 11) begin
            chk("unlock_3bad", {39'b0, locked}, 40'd0);
            chk("hdr_5", {24'b0, hdr_err_cnt}, 40'd5);
         end
      end
      chk("n_corrupt", 40'(nf), 40'd8);
      clr_cnt = 1'b1;
      cyc();
      clr_cnt = 1'b0;
      chk("hdr_clr", {24'b0, hdr_err_cnt}, 40'd0);
      // 8 bits/cycle: one frame every 5 cycles
      reset_dut(2'b00);
      for (int i = 0; i < 10; i++) push_frame(mk(16'h3C5C, i + 60));
      ei = 4;
      while (bq.size() > 0) begin
         cyc();
         if (frame_valid && nf > 1) chk("gap8", 40'(gap), 40'd5);
      end
      chk("n_rate8", 40'(nf), 40'd6);
      // 16 bits/cycle: gaps alternate 2 and 3
      reset_dut(2'b01);
      for (int i = 0; i < 10; i++) push_frame(mk(16'h3C5C, i + 80));
      ei = 4;
      while (bq.size() > 0) begin
         cyc();
         if (frame_valid && nf > 1) chk("gap16", {39'b0, gap == 2 || gap == 3}, 40'd1);
      end
      chk("n_rate16", 40'(nf), 40'd6);
      chk("lock_rate16", {39'b0, locked}, 40'd1);
      rate = 2'b10;
      cyc();
      chk("unlock_ratechg", {39'b0, locked}, 40'd0);
      chk("no_emit_ratechg", {39'b0, frame_valid}, 40'd0);
      ei = expf.size() + 4;
      nf = 0;
      for (int i = 0; i < 8; i++) push_frame(mk(16'h3C5C, i + 100));
      while (bq.size() > 0) cyc();
      chk("n_relock", 40'(nf), 40'd4);
      chk("relock", {39'b0, locked}, 40'd1);
      // din_err saturation and clear priority
      din_err = 1'b1;
      repeat (65534) @(posedge clk);
      #1;
      chk("dinerr_65534", {24'b0, din_err_cnt}, 40'hFFFE);
      repeat (6) @(posedge clk);
      #1;
      chk("dinerr_sat", {24'b0, din_err_cnt}, 40'hFFFF);
      clr_cnt = 1'b1;
      @(posedge clk);
      #1;
      chk("dinerr_clr", {24'b0, din_err_cnt}, 40'd0);
      clr_cnt = 1'b0;
      @(posedge clk);
      #1;
      chk("dinerr_after_clr", {24'b0, din_err_cnt}, 40'd1);
      din_err = 1'b0;
      // reset while locked, then relock from scratch
      reset_dut(2'b10);
      for (int i = 0; i < 8; i++) push_frame(mk(16'h3C5C, i + 120));
      ei = 4;
      repeat (7) cyc();
      chk("lock_pre_rst", {39'b0, locked}, 40'd1);
      chk("valid_pre_rst", {39'b0, frame_valid}, 40'd1);
      #2;
      reset = 1'b0;
      #1;
      chk("mrst_frame", frame, 40'h0);
      chk("mrst_valid", {39'b0, frame_valid}, 40'd0);
      chk("mrst_locked", {39'b0, locked}, 40'd0);
      chk("mrst_hdr", {24'b0, hdr_err_cnt}, 40'd0);
      chk("mrst_dinerr", {24'b0, din_err_cnt}, 40'd0);
      reset_dut(2'b10);
      for (int i = 0; i < 8; i++) push_frame(mk(16'h3C5C, i + 140));
      ei = 4;
      while (bq.size() > 0) cyc();
      chk("n_post_rst", 40'(nf), 40'd4);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
